// File: rtl/game_timer_ctrl.sv
// game_timer_ctrl: 1 Hz countdown for the timed game modes.
// A start pulse loads a clamped MM:SS duration. A prescaler divides the system
// clock down to seconds. The remaining time is kept twice: once in binary and
// once as three BCD digits, and both count down in lockstep. All outputs are
// registered.
module game_timer_ctrl #(
  parameter int TICKS_PER_SEC = 74_250_000,
  parameter int WARN_SECONDS  = 10
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       start_in,
  input  logic       pause_in,
  input  logic       abort_in,
  input  logic [3:0] dur_min_in,
  input  logic [5:0] dur_sec_in,
  output logic       running_out,
  output logic       paused_out,
  output logic       timer_done_out,
  output logic       expired_out,
  output logic       sec_tick_out,
  output logic       warn_out,
  output logic [9:0] secs_left_out,
  output logic [3:0] bcd_min_out,
  output logic [3:0] bcd_sec_tens_out,
  output logic [3:0] bcd_sec_ones_out
);

  // The prescaler needs at least one bit, even when one tick lasts one cycle.
  localparam int            PW         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(TICKS_PER_SEC - 1);
  localparam logic [9:0]    WARN_LIMIT = 10'(WARN_SECONDS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic [9:0]    secs_reg, secs_next;

  // Digit index: 0 = seconds ones, 1 = seconds tens, 2 = minutes.
  logic [3:0]    digit_reg  [3];
  logic [3:0]    digit_next [3];
  logic [3:0]    digit_dec  [3];
  logic [2:0]    borrow;

  logic          done_reg, done_next;
  logic          tick_reg, tick_next;
  logic          running_reg, running_next;
  logic          paused_reg, paused_next;
  logic          expired_reg, expired_next;
  logic          warn_reg, warn_next;

  // Load path. The divide and modulo by 10 act only on the clamped seconds
  // input, which is a small constant-divisor lookup. They never appear in
  // the per-second countdown path.
  logic [3:0]    load_min;
  logic [5:0]    load_sec;
  logic [9:0]    load_secs;
  logic [3:0]    load_tens;
  logic [3:0]    load_ones;

  assign load_min  = (dur_min_in > 4'd9)  ? 4'd9  : dur_min_in;
  assign load_sec  = (dur_sec_in > 6'd59) ? 6'd59 : dur_sec_in;
  assign load_secs = 10'(load_min) * 10'd60 + 10'(load_sec);
  assign load_tens = 4'(load_sec / 6'd10);
  assign load_ones = 4'(load_sec % 6'd10);

  // Digit-wise decrement with a borrow chain. The ones digit always takes the
  // decrement. A digit at 0 wraps to its maximum value and passes the borrow
  // to the next digit. This result is only used on a tick, and ticks only
  // happen while the count is nonzero, so the minutes digit never wraps.
  assign borrow[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_digit
      localparam logic [3:0] DIGIT_MAX = (gi == 1) ? 4'd5 : 4'd9;

      assign digit_dec[gi] = !borrow[gi]              ? digit_reg[gi] :
                             (digit_reg[gi] == 4'd0)  ? DIGIT_MAX     :
                                                        digit_reg[gi] - 4'd1;

      if (gi < 2) begin : g_borrow
        assign borrow[gi+1] = borrow[gi] && (digit_reg[gi] == 4'd0);
      end
    end
  endgenerate

  // Next-state and next-output logic. The priority order is abort, then start,
  // then the countdown. In the countdown, pause suppresses the tick.
  always_comb begin
    state_next = state_reg;
    presc_next = presc_reg;
    secs_next  = secs_reg;
    digit_next = digit_reg;
    done_next  = 1'b0;
    tick_next  = 1'b0;

    if (abort_in) begin
      state_next = IDLE;
      presc_next = '0;
      secs_next  = '0;
      digit_next = '{default: 4'd0};
    end else if (start_in) begin
      presc_next    = '0;
      secs_next     = load_secs;
      digit_next[2] = load_min;
      digit_next[1] = load_tens;
      digit_next[0] = load_ones;
      if (load_secs == 10'd0) begin
        state_next = EXPIRED;
        done_next  = 1'b1;
      end else begin
        state_next = pause_in ? PAUSED : RUN;
      end
    end else begin
      case (state_reg)
        RUN, PAUSED: begin
          if (pause_in) begin
            // The prescaler freezes, even when it is at the wrap point.
            state_next = PAUSED;
          end else begin
            state_next = RUN;
            if (presc_reg == PRESC_MAX) begin
              presc_next = '0;
              tick_next  = 1'b1;
              secs_next  = secs_reg - 10'd1;
              digit_next = digit_dec;
              if (secs_reg == 10'd1) begin
                state_next = EXPIRED;
                done_next  = 1'b1;
              end
            end else begin
              presc_next = presc_reg + PW'(1);
            end
          end
        end
        default: begin
          // IDLE and EXPIRED hold their counters until start or abort.
        end
      endcase
    end

    running_next = (state_next == RUN) || (state_next == PAUSED);
    paused_next  = (state_next == PAUSED);
    expired_next = (state_next == EXPIRED);
    warn_next    = running_next && (secs_next <= WARN_LIMIT) && (secs_next != 10'd0);
  end

  // State, counter and output registers. The active-low reset is synchronous.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_reg   <= IDLE;
      presc_reg   <= '0;
      secs_reg    <= '0;
      digit_reg   <= '{default: 4'd0};
      done_reg    <= 1'b0;
      tick_reg    <= 1'b0;
      running_reg <= 1'b0;
      paused_reg  <= 1'b0;
      expired_reg <= 1'b0;
      warn_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      presc_reg   <= presc_next;
      secs_reg    <= secs_next;
      digit_reg   <= digit_next;
      done_reg    <= done_next;
      tick_reg    <= tick_next;
      running_reg <= running_next;
      paused_reg  <= paused_next;
      expired_reg <= expired_next;
      warn_reg    <= warn_next;
    end
  end

  assign running_out      = running_reg;
  assign paused_out       = paused_reg;
  assign timer_done_out   = done_reg;
  assign expired_out      = expired_reg;
  assign sec_tick_out     = tick_reg;
  assign warn_out         = warn_reg;
  assign secs_left_out    = secs_reg;
  assign bcd_min_out      = digit_reg[2];
  assign bcd_sec_tens_out = digit_reg[1];
  assign bcd_sec_ones_out = digit_reg[0];

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Testbench for game_timer_ctrl with TICKS_PER_SEC=4.
// Each scenario first pushes its expected (cycle, output, value) entries into a
// scoreboard. It then clocks the DUT and pops and compares every entry that
// falls due in the current cycle. Cycle 0 is the cycle in which the scenario
// drives its start pulse.
module tb_game_timer_ctrl;

  localparam int TPS  = 4;
  localparam int WARN = 10;

  localparam int K_RUN   = 0;
  localparam int K_PAUSE = 1;
  localparam int K_DONE  = 2;
  localparam int K_EXP   = 3;
  localparam int K_TICK  = 4;
  localparam int K_WARN  = 5;
  localparam int K_SECS  = 6;
  localparam int K_BMIN  = 7;
  localparam int K_BTENS = 8;
  localparam int K_BONES = 9;

  logic       clk_in     = 1'b0;
  logic       rst_n_in   = 1'b0;
  logic       start_in   = 1'b0;
  logic       pause_in   = 1'b0;
  logic       abort_in   = 1'b0;
  logic [3:0] dur_min_in = 4'd0;
  logic [5:0] dur_sec_in = 6'd0;
  logic       running_out;
  logic       paused_out;
  logic       timer_done_out;
  logic       expired_out;
  logic       sec_tick_out;
  logic       warn_out;
  logic [9:0] secs_left_out;
  logic [3:0] bcd_min_out;
  logic [3:0] bcd_sec_tens_out;
  logic [3:0] bcd_sec_ones_out;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } exp_t;

  exp_t  sb[$];
  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  string tname    = "";

  game_timer_ctrl #(
    .TICKS_PER_SEC (TPS),
    .WARN_SECONDS  (WARN)
  ) dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .start_in         (start_in),
    .pause_in         (pause_in),
    .abort_in         (abort_in),
    .dur_min_in       (dur_min_in),
    .dur_sec_in       (dur_sec_in),
    .running_out      (running_out),
    .paused_out       (paused_out),
    .timer_done_out   (timer_done_out),
    .expired_out      (expired_out),
    .sec_tick_out     (sec_tick_out),
    .warn_out         (warn_out),
    .secs_left_out    (secs_left_out),
    .bcd_min_out      (bcd_min_out),
    .bcd_sec_tens_out (bcd_sec_tens_out),
    .bcd_sec_ones_out (bcd_sec_ones_out)
  );

  always #5 clk_in = ~clk_in;

  // Advance one clock. Outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  task automatic expect_at(input int c, input int k, input int v);
    exp_t e;
    e.cyc  = c;
    e.kind = k;
    e.val  = v;
    sb.push_back(e);
  endtask

  function automatic int obs(input int k);
    case (k)
      K_RUN:   return int'(running_out);
      K_PAUSE: return int'(paused_out);
      K_DONE:  return int'(timer_done_out);
      K_EXP:   return int'(expired_out);
      K_TICK:  return int'(sec_tick_out);
      K_WARN:  return int'(warn_out);
      K_SECS:  return int'(secs_left_out);
      K_BMIN:  return int'(bcd_min_out);
      K_BTENS: return int'(bcd_sec_tens_out);
      default: return int'(bcd_sec_ones_out);
    endcase
  endfunction

  function automatic string kname(input int k);
    case (k)
      K_RUN:   return "running_out";
      K_PAUSE: return "paused_out";
      K_DONE:  return "timer_done_out";
      K_EXP:   return "expired_out";
      K_TICK:  return "sec_tick_out";
      K_WARN:  return "warn_out";
      K_SECS:  return "secs_left_out";
      K_BMIN:  return "bcd_min_out";
      K_BTENS: return "bcd_sec_tens_out";
      default: return "bcd_sec_ones_out";
    endcase
  endfunction

  task automatic test_reset();
    tname = "reset";
    cyc = 0;
    rst_n_in = 1'b0;
    start_in = 1'b1;
    dur_sec_in = 6'd5;
    for (int k = 0; k < 10; k++) begin
      expect_at(1, k, 0);
      expect_at(2, k, 0);
    end
    for (int k = 1; k <= 2; k++) begin
      step();
      for (int i = 0; i < sb.size(); ) begin
        if (sb[i].cyc == cyc) begin
          checks++;
          if (obs(sb[i].kind) !== sb[i].val) begin
            failures++;
            $display("FAIL %s %s cyc=%0d actual=%0d required=%0d", tname, kname(sb[i].kind), cyc, obs(sb[i].kind), sb[i].val);
          end
          sb.delete(i);
        end else i++;
      end
    end
    rst_n_in = 1'b1;
    start_in = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s sb_drain pending=%0d required=0", tname, sb.size());
      sb.delete();
    end
    $display("scenario %s done checks=%0d failures=%0d", tname, checks, failures);
  endtask

  task automatic test_countdown();
    tname = "countdown_0_03";
    cyc = 0;
    start_in = 1'b1; dur_min_in = 4'd0; dur_sec_in = 6'd3;
    expect_at(1, K_RUN, 1);   expect_at(1, K_SECS, 3);  expect_at(1, K_BONES, 3);
    expect_at(1, K_WARN, 1);  expect_at(1, K_DONE, 0);  expect_at(4, K_SECS, 3);
    expect_at(5, K_SECS, 2);  expect_at(5, K_TICK, 1);  expect_at(5, K_BONES, 2);
    expect_at(6, K_TICK, 0);  expect_at(9, K_SECS, 1);  expect_at(12, K_DONE, 0);
    expect_at(13, K_SECS, 0); expect_at(13, K_DONE, 1); expect_at(13, K_EXP, 1);
    expect_at(13, K_RUN, 0);  expect_at(13, K_WARN, 0); expect_at(14, K_DONE, 0);
    expect_at(14, K_EXP, 1);  expect_at(14, K_SECS, 0);
    for (int k = 1; k <= 15; k++) begin
      step();
      start_in = 1'b0;
      for (int i = 0; i < sb.size(); ) begin
        if (sb[i].cyc == cyc) begin
          checks++;
          if (obs(sb[i].kind) !== sb[i].val) begin
            failures++;
            $display("FAIL %s %s cyc=%0d actual=%0d required=%0d", tname, kname(sb[i].kind), cyc, obs(sb[i].kind), sb[i].val);
          end
          sb.delete(i);
        end else i++;
      end
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s sb_drain pending=%0d required=0", tname, sb.size());
      sb.delete();
    end
    $display("scenario %s done checks=%0d failures=%0d", tname, checks, failures);
  endtask

  // Starts from EXPIRED (left by the previous scenario), so expired_out must drop.
  task automatic test_bcd_borrow();
    tname = "bcd_borrow_1_00";
    cyc = 0;
    start_in = 1'b1; dur_min_in = 4'd1; dur_sec_in = 6'd0;
    expect_at(1, K_SECS, 60); expect_at(1, K_BMIN, 1);  expect_at(1, K_BTENS, 0);
    expect_at(1, K_BONES, 0); expect_at(1, K_EXP, 0);   expect_at(1, K_WARN, 0);
    expect_at(5, K_SECS, 59); expect_at(5, K_BMIN, 0);  expect_at(5, K_BTENS, 5);
    expect_at(5, K_BONES, 9); expect_at(6, K_RUN, 0);   expect_at(6, K_SECS, 0);
    expect_at(6, K_BTENS, 0); expect_at(6, K_BONES, 0); expect_at(6, K_DONE, 0);
    for (int k = 1; k <= 7; k++) begin
      step();
      start_in = 1'b0;
      abort_in = 1'b0;
      for (int i = 0; i < sb.size(); ) begin
        if (sb[i].cyc == cyc) begin
          checks++;
          if (obs(sb[i].kind) !== sb[i].val) begin
            failures++;
            $display("FAIL %s %s cyc=%0d actual=%0d required=%0d", tname, kname(sb[i].kind), cyc, obs(sb[i].kind), sb[i].val);
          end
          sb.delete(i);
        end else i++;
      end
      if (cyc == 5) abort_in = 1'b1;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s sb_drain pending=%0d required=0", tname, sb.size());
      sb.delete();
    end
    $display("scenario %s done checks=%0d failures=%0d", tname, checks, failures);
  endtask

  // Without a pause, the ticks land on cycles 5, 9, 13, 17 and 21. pause_in
  // is high for the 10 edges that end cycles 7..16, so every tick after the
  // pause moves 10 cycles later: 19, 23, 27 and 31.
  task automatic test_pause();
    tname = "pause_0_05";
    cyc = 0;
    start_in = 1'b1; dur_min_in = 4'd0; dur_sec_in = 6'd5;
    expect_at(5, K_SECS, 4);  expect_at(5, K_TICK, 1);
    for (int c = 6; c <= 18; c++) expect_at(c, K_TICK, 0);
    expect_at(8, K_PAUSE, 1);  expect_at(8, K_RUN, 1);   expect_at(8, K_SECS, 4);
    expect_at(10, K_WARN, 1);  expect_at(17, K_PAUSE, 1); expect_at(17, K_SECS, 4);
    expect_at(18, K_PAUSE, 0); expect_at(18, K_SECS, 4);  expect_at(19, K_SECS, 3);
    expect_at(19, K_TICK, 1);  expect_at(21, K_SECS, 3);  expect_at(30, K_SECS, 1);
    expect_at(30, K_DONE, 0);  expect_at(31, K_SECS, 0);  expect_at(31, K_DONE, 1);
    expect_at(31, K_EXP, 1);   expect_at(32, K_DONE, 0);
    for (int k = 1; k <= 33; k++) begin
      step();
      start_in = 1'b0;
      for (int i = 0; i < sb.size(); ) begin
        if (sb[i].cyc == cyc) begin
          checks++;
          if (obs(sb[i].kind) !== sb[i].val) begin
            failures++;
            $display("FAIL %s %s cyc=%0d actual=%0d required=%0d", tname, kname(sb[i].kind), cyc, obs(sb[i].kind), sb[i].val);
          end
          sb.delete(i);
        end else i++;
      end
      if (cyc == 7)  pause_in = 1'b1;
      if (cyc == 17) pause_in = 1'b0;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s sb_drain pending=%0d required=0", tname, sb.size());
      sb.delete();
    end
    $display("scenario %s done checks=%0d failures=%0d", tname, checks, failures);
  endtask

  // dur_sec_in is 6 bits wide, so 63 is the largest out-of-range seconds
  // value it can carry. 12:63 must clamp to 9:59.
  task automatic test_clamp_warn();
    tname = "clamp_warn";
    cyc = 0;
    start_in = 1'b1; dur_min_in = 4'd12; dur_sec_in = 6'd63;
    expect_at(1, K_SECS, 599);    expect_at(1, K_BMIN, 9);     expect_at(1, K_BTENS, 5);
    expect_at(1, K_BONES, 9);     expect_at(1, K_WARN, 0);     expect_at(5, K_SECS, 598);
    expect_at(5, K_BONES, 8);     expect_at(237, K_SECS, 540); expect_at(237, K_BMIN, 9);
    expect_at(241, K_SECS, 539);  expect_at(241, K_BMIN, 8);   expect_at(241, K_BTENS, 5);
    expect_at(241, K_BONES, 9);   expect_at(2353, K_SECS, 11); expect_at(2356, K_WARN, 0);
    expect_at(2357, K_SECS, 10);  expect_at(2357, K_WARN, 1);  expect_at(2357, K_BMIN, 0);
    expect_at(2357, K_BTENS, 1);  expect_at(2357, K_BONES, 0); expect_at(2361, K_SECS, 9);
    expect_at(2361, K_BTENS, 0);  expect_at(2361, K_BONES, 9); expect_at(2362, K_WARN, 0);
    expect_at(2362, K_RUN, 0);
    for (int k = 1; k <= 2362; k++) begin
      step();
      start_in = 1'b0;
      abort_in = 1'b0;
      for (int i = 0; i < sb.size(); ) begin
        if (sb[i].cyc == cyc) begin
          checks++;
          if (obs(sb[i].kind) !== sb[i].val) begin
            failures++;
            $display("FAIL %s %s cyc=%0d actual=%0d required=%0d", tname, kname(sb[i].kind), cyc, obs(sb[i].kind), sb[i].val);
          end
          sb.delete(i);
        end else i++;
      end
      if (cyc == 2361) abort_in = 1'b1;
    end
    abort_in = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s sb_drain pending=%0d required=0", tname, sb.size());
      sb.delete();
    end
    $display("scenario %s done checks=%0d failures=%0d", tname, checks, failures);
  endtask

  task automatic test_start_abort();
    tname = "start_abort_same";
    cyc = 0;
    start_in = 1'b1; dur_min_in = 4'd0; dur_sec_in = 6'd5;
    expect_at(2, K_RUN, 1);  expect_at(3, K_RUN, 0);   expect_at(3, K_SECS, 0);
    expect_at(3, K_EXP, 0);  expect_at(3, K_DONE, 0);  expect_at(3, K_BONES, 0);
    expect_at(4, K_RUN, 0);
    for (int k = 1; k <= 4; k++) begin
      step();
      start_in = 1'b0;
      abort_in = 1'b0;
      for (int i = 0; i < sb.size(); ) begin
        if (sb[i].cyc == cyc) begin
          checks++;
          if (obs(sb[i].kind) !== sb[i].val) begin
            failures++;
            $display("FAIL %s %s cyc=%0d actual=%0d required=%0d", tname, kname(sb[i].kind), cyc, obs(sb[i].kind), sb[i].val);
          end
          sb.delete(i);
        end else i++;
      end
      if (cyc == 2) begin
        start_in = 1'b1; abort_in = 1'b1; dur_sec_in = 6'd7;
      end
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s sb_drain pending=%0d required=0", tname, sb.size());
      sb.delete();
    end
    $display("scenario %s done checks=%0d failures=%0d", tname, checks, failures);
  endtask

  task automatic test_restart();
    tname = "restart_at_2";
    cyc = 0;
    start_in = 1'b1; dur_min_in = 4'd0; dur_sec_in = 6'd3;
    expect_at(5, K_SECS, 2);  expect_at(6, K_SECS, 7);  expect_at(6, K_BONES, 7);
    expect_at(6, K_RUN, 1);   expect_at(6, K_TICK, 0);
    for (int c = 6; c <= 10; c++) expect_at(c, K_DONE, 0);
    expect_at(9, K_SECS, 7);  expect_at(10, K_SECS, 6); expect_at(10, K_TICK, 1);
    expect_at(11, K_RUN, 0);
    for (int k = 1; k <= 11; k++) begin
      step();
      start_in = 1'b0;
      abort_in = 1'b0;
      for (int i = 0; i < sb.size(); ) begin
        if (sb[i].cyc == cyc) begin
          checks++;
          if (obs(sb[i].kind) !== sb[i].val) begin
            failures++;
            $display("FAIL %s %s cyc=%0d actual=%0d required=%0d", tname, kname(sb[i].kind), cyc, obs(sb[i].kind), sb[i].val);
          end
          sb.delete(i);
        end else i++;
      end
      if (cyc == 5) begin
        start_in = 1'b1; dur_sec_in = 6'd7;
      end
      if (cyc == 10) abort_in = 1'b1;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s sb_drain pending=%0d required=0", tname, sb.size());
      sb.delete();
    end
    $display("scenario %s done checks=%0d failures=%0d", tname, checks, failures);
  endtask

  task automatic test_zero();
    tname = "zero_duration";
    cyc = 0;
    start_in = 1'b1; dur_min_in = 4'd0; dur_sec_in = 6'd0;
    expect_at(1, K_EXP, 1);  expect_at(1, K_DONE, 1); expect_at(1, K_SECS, 0);
    expect_at(1, K_RUN, 0);  expect_at(1, K_TICK, 0); expect_at(1, K_WARN, 0);
    expect_at(2, K_DONE, 0); expect_at(2, K_EXP, 1);  expect_at(6, K_EXP, 1);
    expect_at(6, K_SECS, 0); expect_at(7, K_EXP, 0);  expect_at(7, K_RUN, 1);
    expect_at(7, K_SECS, 2);
    for (int k = 1; k <= 8; k++) begin
      step();
      start_in = 1'b0;
      abort_in = 1'b0;
      for (int i = 0; i < sb.size(); ) begin
        if (sb[i].cyc == cyc) begin
          checks++;
          if (obs(sb[i].kind) !== sb[i].val) begin
            failures++;
            $display("FAIL %s %s cyc=%0d actual=%0d required=%0d", tname, kname(sb[i].kind), cyc, obs(sb[i].kind), sb[i].val);
          end
          sb.delete(i);
        end else i++;
      end
      if (cyc == 6) begin
        start_in = 1'b1; dur_sec_in = 6'd2;
      end
      if (cyc == 7) abort_in = 1'b1;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s sb_drain pending=%0d required=0", tname, sb.size());
      sb.delete();
    end
    $display("scenario %s done checks=%0d failures=%0d", tname, checks, failures);
  endtask

  task automatic test_reset_mid();
    tname = "reset_mid_count";
    cyc = 0;
    start_in = 1'b1; dur_min_in = 4'd0; dur_sec_in = 6'd5;
    expect_at(5, K_SECS, 4);
    for (int k = 0; k < 10; k++) expect_at(6, k, 0);
    expect_at(7, K_RUN, 0); expect_at(7, K_SECS, 0);
    expect_at(8, K_RUN, 0); expect_at(8, K_SECS, 0);
    for (int k = 1; k <= 8; k++) begin
      step();
      start_in = 1'b0;
      for (int i = 0; i < sb.size(); ) begin
        if (sb[i].cyc == cyc) begin
          checks++;
          if (obs(sb[i].kind) !== sb[i].val) begin
            failures++;
            $display("FAIL %s %s cyc=%0d actual=%0d required=%0d", tname, kname(sb[i].kind), cyc, obs(sb[i].kind), sb[i].val);
          end
          sb.delete(i);
        end else i++;
      end
      if (cyc == 5) rst_n_in = 1'b0;
      if (cyc == 6) start_in = 1'b1;
      if (cyc == 7) rst_n_in = 1'b1;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s sb_drain pending=%0d required=0", tname, sb.size());
      sb.delete();
    end
    $display("scenario %s done checks=%0d failures=%0d", tname, checks, failures);
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_bcd_borrow();
    test_pause();
    test_clamp_warn();
    test_start_abort();
    test_restart();
    test_zero();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
